controller_instruction_loader: RTL and testbench



---
 rtl/controller_instruction_loader_if.sv | 29 ++
 rtl/controller_instruction_loader.sv | 203 ++++++++++++++++++++
 tb/tb_controller_instruction_loader.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controller_instruction_loader_if.sv
// rtl/controller_instruction_loader_if.sv - byte stream and instruction-memory port 2 bundle for the loader
interface controller_instruction_loader_if #(
  parameter int ADDR_WIDTH = 13
);
  logic [7:0]            st_data;
  logic                  st_valid;
  logic                  st_ready;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_writedata;
  logic [3:0]            mem_byteenable;
  logic                  mem_chipselect;
  logic                  mem_write;
  logic                  mem_debugaccess;
  logic [31:0]           mem_readdata;

  // Loader side: consumes the stream, drives the memory port.
  modport master (
    input  st_data, st_valid, mem_readdata,
    output st_ready, mem_address, mem_writedata, mem_byteenable,
           mem_chipselect, mem_write, mem_debugaccess
  );

  // Environment side: stream source and instruction memory.
  modport slave (
    output st_data, st_valid, mem_readdata,
    input  st_ready, mem_address, mem_writedata, mem_byteenable,
           mem_chipselect, mem_write, mem_debugaccess
  );
endinterface

// File: rtl/controller_instruction_loader.sv
// rtl/controller_instruction_loader.sv - boot loader writing a length-prefixed, checksummed image into instruction memory; LOADER_VERIFY_EN adds a read-back pass
module controller_instruction_loader #(
  parameter int          ADDR_WIDTH     = 13,
  parameter int unsigned MAX_WORDS      = 8192,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  controller_instruction_loader_if.master bus,
  output logic                            cpu_reset_req,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [1:0]                      error_code
);
  // Word counter is one bit wider than the address so it can hold N itself.
  localparam int            CW       = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] IDX_ONE  = 1;
  localparam logic [1:0]    ERR_LEN  = 2'd1;
  localparam logic [1:0]    ERR_CSUM = 2'd2;
  localparam logic [1:0]    ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_VERIFY, S_DONE, S_ERROR
  } state_t;

  state_t        state, state_next;
  logic [1:0]    byte_cnt;
  logic [31:0]   word_q;
  logic [31:0]   acc;
  logic [31:0]   timer;
  logic [CW-1:0] n_q;
  logic [CW-1:0] idx;
  logic [1:0]    err_q;

  logic          accept, last_byte, timeout_hit, idle_like, set_err, rd_issue;
  logic [1:0]    err_val;
  logic [31:0]   assembled;

  assign accept      = bus.st_valid && bus.st_ready;
  assign last_byte   = accept && (byte_cnt == 2'd3);
  // The completed little-endian word, valid in the cycle its last byte arrives.
  assign assembled   = {bus.st_data, word_q[23:0]};
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TIMEOUT_CYCLES);
  assign idle_like   = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

`ifdef LOADER_VERIFY_EN
  logic        rd_pending;
  logic [31:0] vsum;
  assign rd_issue = (state == S_VERIFY) && (idx < n_q);
`else
  logic unused_readdata;
  assign rd_issue        = 1'b0;
  assign unused_readdata = ^bus.mem_readdata;
`endif

  // State register; reset aborts any load in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode plus Moore-style outputs derived from the state register.
  always_comb begin
    state_next          = state;
    set_err             = 1'b0;
    err_val             = 2'd0;
    bus.st_ready        = 1'b0;
    bus.mem_chipselect  = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_debugaccess = 1'b0;
    bus.mem_byteenable  = 4'hF;
    bus.mem_address     = idx[ADDR_WIDTH-1:0];
    bus.mem_writedata   = word_q;
    busy                = 1'b0;
    done                = (state == S_DONE);
    error               = (state == S_ERROR);
    cpu_reset_req       = (state != S_DONE);
    error_code          = err_q;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_next = S_LEN;
      end
      S_LEN: begin
        busy         = 1'b1;
        bus.st_ready = 1'b1;
        if (timeout_hit) begin
          state_next = S_ERROR; set_err = 1'b1; err_val = ERR_TMO;
        end else if (last_byte) begin
          if ((assembled == 32'd0) || (assembled > MAX_WORDS)) begin
            state_next = S_ERROR; set_err = 1'b1; err_val = ERR_LEN;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        busy         = 1'b1;
        bus.st_ready = 1'b1;
        if (timeout_hit) begin
          state_next = S_ERROR; set_err = 1'b1; err_val = ERR_TMO;
        end else if (last_byte) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        busy                = 1'b1;
        bus.mem_chipselect  = 1'b1;
        bus.mem_write       = 1'b1;
        bus.mem_debugaccess = 1'b1;
        state_next          = ((idx + IDX_ONE) == n_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        busy         = 1'b1;
        bus.st_ready = 1'b1;
        if (timeout_hit) begin
          state_next = S_ERROR; set_err = 1'b1; err_val = ERR_TMO;
        end else if (last_byte) begin
          if (assembled == acc) begin
`ifdef LOADER_VERIFY_EN
            state_next = S_VERIFY;
`else
            state_next = S_DONE;
`endif
          end else begin
            state_next = S_ERROR; set_err = 1'b1; err_val = ERR_CSUM;
          end
        end
      end
      S_VERIFY: begin
`ifdef LOADER_VERIFY_EN
        busy               = 1'b1;
        bus.mem_chipselect = rd_issue;
        if (!rd_issue && !rd_pending) begin
          if (vsum == acc) begin
            state_next = S_DONE;
          end else begin
            state_next = S_ERROR; set_err = 1'b1; err_val = ERR_TMO;
          end
        end
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Byte assembly, word index, running sum, idle timer and error latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      word_q   <= 32'd0;
      acc      <= 32'd0;
      timer    <= 32'd0;
      n_q      <= '0;
      idx      <= '0;
      err_q    <= 2'd0;
`ifdef LOADER_VERIFY_EN
      rd_pending <= 1'b0;
      vsum       <= 32'd0;
`endif
    end else begin
      if (accept || idle_like) timer <= 32'd0;
      else                     timer <= timer + 32'd1;

      if (accept) begin
        word_q[{byte_cnt, 3'b000} +: 8] <= bus.st_data;
        byte_cnt                        <= byte_cnt + 2'd1;
      end

      if (idle_like && start) begin
        byte_cnt <= 2'd0;
        idx      <= '0;
        acc      <= 32'd0;
        err_q    <= 2'd0;
      end

      if ((state == S_LEN) && (state_next == S_DATA)) n_q <= assembled[CW-1:0];

      if (state == S_WRITE) begin
        acc <= acc + word_q;
        idx <= idx + IDX_ONE;
      end

      if (set_err) err_q <= err_val;

`ifdef LOADER_VERIFY_EN
      // Read-back pass: one address per cycle, data summed a cycle later.
      if ((state == S_CSUM) && (state_next == S_VERIFY)) begin
        idx        <= '0;
        vsum       <= 32'd0;
        rd_pending <= 1'b0;
      end else if (state == S_VERIFY) begin
        if (rd_issue)   idx  <= idx + IDX_ONE;
        if (rd_pending) vsum <= vsum + bus.mem_readdata;
        rd_pending <= rd_issue;
      end
`endif
    end
  end
endmodule

// File: tb/tb_controller_instruction_loader.sv
// tb/tb_controller_instruction_loader.sv - directed self-checking bench for controller_instruction_loader
module tb_controller_instruction_loader;
  localparam int AW    = 13;
  localparam int DEPTH = 1 << AW;
`ifdef LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cpu_reset_req, busy, done, error;
  logic [1:0] error_code;

  controller_instruction_loader_if #(.ADDR_WIDTH(AW)) bus ();

  controller_instruction_loader #(
    .ADDR_WIDTH(AW), .MAX_WORDS(8192), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(rst), .start(start), .bus(bus),
    .cpu_reset_req(cpu_reset_req), .busy(busy), .done(done),
    .error(error), .error_code(error_code)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          aborted = 1'b0;
  logic [31:0] mem [0:DEPTH-1];
  int          wr_cnt [0:DEPTH-1];
  int          wr_total = 0;
  int          rd_total = 0;
  int          rd_ever = 0;
  logic [31:0] last_wr_addr = 32'd0;
  bit          bad_strobe = 1'b0;
  bit          corrupt = 1'b0;
  logic [31:0] img [0:DEPTH-1];

  // Memory model: records writes mid-cycle, returns read data one cycle after the address.
  always @(negedge clk) begin
    if (bus.mem_debugaccess !== bus.mem_write || bus.mem_byteenable !== 4'hF) bad_strobe = 1'b1;
    if (!rst && bus.mem_chipselect && bus.mem_write) begin
      mem[bus.mem_address]    = bus.mem_writedata;
      wr_cnt[bus.mem_address] = wr_cnt[bus.mem_address] + 1;
      wr_total                = wr_total + 1;
      last_wr_addr            = 32'(bus.mem_address);
    end
    if (!rst && bus.mem_chipselect && !bus.mem_write) begin
      rd_total = rd_total + 1;
      rd_ever  = rd_ever + 1;
    end
  end

  always @(posedge clk)
    bus.mem_readdata <= mem[bus.mem_address] ^ ((corrupt && bus.mem_address == 13'd5) ? 32'h1 : 32'h0);

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < DEPTH; i++) wr_cnt[i] = 0;
    wr_total     = 0;
    rd_total     = 0;
    last_wr_addr = 32'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited;
    if (aborted) return;
    if (gaps && $urandom_range(0, 15) == 0) begin
      bus.st_valid = 1'b0;
      step();
    end
    bus.st_data  = b;
    bus.st_valid = 1'b1;
    waited = 0;
    while (!bus.st_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!bus.st_ready) begin
      check("stream_ready", 32'(bus.st_ready), 32'd1);
      aborted      = 1'b1;
      bus.st_valid = 1'b0;
      return;
    end
    step();
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  task automatic load_image(input int n, input logic [31:0] csum, input bit gaps);
    send_word(32'(n), gaps);
    for (int i = 0; i < n; i++) send_word(img[i], gaps);
    send_word(csum, gaps);
    bus.st_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(done || error), 32'd1);
  endtask

  logic [31:0] sum;

  initial begin
    bus.st_data  = 8'h00;
    bus.st_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    clear_mon();

    // Reset values.
    step(); step();
    check("rst_st_ready", 32'(bus.st_ready), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_mem_cs", 32'(bus.mem_chipselect), 32'd0);
    check("rst_mem_dbg", 32'(bus.mem_debugaccess), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_address), 32'd0);
    check("rst_mem_wdata", bus.mem_writedata, 32'd0);
    check("rst_mem_be", 32'(bus.mem_byteenable), 32'hF);
    check("rst_cpu_reset", 32'(cpu_reset_req), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_error_code", 32'(error_code), 32'd0);
    rst = 1'b0;
    step();

    // Bytes offered while idle are refused.
    bus.st_data = 8'hAA; bus.st_valid = 1'b1;
    step();
    check("idle_st_ready", 32'(bus.st_ready), 32'd0);
    bus.st_valid = 1'b0;

    // Good two-word image; 0x11223344 + 0xDEADBEEF = 0xEFCFF233. A stray start mid-load is ignored.
    img[0] = 32'h11223344; img[1] = 32'hDEADBEEF;
    clear_mon();
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_cpu_reset", 32'(cpu_reset_req), 32'd1);
    send_word(32'd2, 1'b0);
    send_word(img[0], 1'b0);
    pulse_start();
    send_word(img[1], 1'b0);
    send_word(32'hEFCFF233, 1'b0);
    bus.st_valid = 1'b0;
    wait_end("t1_end", 200);
    step();
    check("t1_done", 32'(done), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    check("t1_cpu_reset", 32'(cpu_reset_req), 32'd0);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_mem0", mem[0], 32'h11223344);
    check("t1_mem1", mem[1], 32'hDEADBEEF);
    check("t1_writes", 32'(wr_total), 32'd2);
    check("t1_reads", 32'(rd_total), VERIFY ? 32'd2 : 32'd0);

    // Same image, checksum off by one.
    clear_mon();
    pulse_start();
    check("t2_done_cleared", 32'(done), 32'd0);
    load_image(2, 32'hEFCFF234, 1'b0);
    wait_end("t2_end", 200);
    check("t2_error", 32'(error), 32'd1);
    check("t2_code", 32'(error_code), 32'd2);
    check("t2_cpu_reset", 32'(cpu_reset_req), 32'd1);
    check("t2_writes", 32'(wr_total), 32'd2);

    // Zero length.
    clear_mon();
    pulse_start();
    check("t3_code_cleared", 32'(error_code), 32'd0);
    send_word(32'd0, 1'b0);
    bus.st_valid = 1'b0;
    wait_end("t3_end", 50);
    check("t3_code", 32'(error_code), 32'd1);
    check("t3_writes", 32'(wr_total), 32'd0);

    // Length one past the maximum.
    clear_mon();
    pulse_start();
    send_word(32'd8193, 1'b0);
    bus.st_valid = 1'b0;
    wait_end("t4_end", 50);
    check("t4_code", 32'(error_code), 32'd1);
    check("t4_writes", 32'(wr_total), 32'd0);

    // Stall after three data bytes of a one-word image.
    clear_mon();
    pulse_start();
    send_word(32'd1, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    bus.st_valid = 1'b0;
    repeat (90) step();
    check("t5_not_yet", 32'(error), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);
    wait_end("t5_end", 30);
    check("t5_error", 32'(error), 32'd1);
    check("t5_code", 32'(error_code), 32'd3);
    check("t5_writes", 32'(wr_total), 32'd0);

    // Recovery with a good one-word image.
    clear_mon();
    img[0] = 32'hCAFEF00D;
    pulse_start();
    load_image(1, 32'hCAFEF00D, 1'b0);
    wait_end("t6_end", 200);
    check("t6_done", 32'(done), 32'd1);
    check("t6_mem0", mem[0], 32'hCAFEF00D);

    // Full-size image with random stream gaps.
    clear_mon();
    sum = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = 32'(i) * 32'h01010101;
      sum    = sum + img[i];
    end
    pulse_start();
    load_image(DEPTH, sum, 1'b1);
    wait_end("t7_end", 20000);
    check("t7_done", 32'(done), 32'd1);
    check("t7_writes", 32'(wr_total), 32'd8192);
    check("t7_last_addr", last_wr_addr, 32'h1FFF);
    begin
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) if (wr_cnt[i] != 1 || mem[i] !== img[i]) bad++;
      check("t7_each_once", 32'(bad), 32'd0);
    end
    check("t7_reads", 32'(rd_total), VERIFY ? 32'd8192 : 32'd0);

    // Rerun, reset hits after word 4000.
    clear_mon();
    pulse_start();
    send_word(32'd8192, 1'b0);
    for (int i = 0; i < 4000; i++) send_word(img[i], 1'b0);
    bus.st_valid = 1'b0;
    step();
    check("t8_writes", 32'(wr_total), 32'd4000);
    check("t8_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t8_st_ready", 32'(bus.st_ready), 32'd0);
    check("t8_mem_write", 32'(bus.mem_write), 32'd0);
    check("t8_mem_cs", 32'(bus.mem_chipselect), 32'd0);
    check("t8_mem_addr", 32'(bus.mem_address), 32'd0);
    check("t8_mem_wdata", bus.mem_writedata, 32'd0);
    check("t8_cpu_reset", 32'(cpu_reset_req), 32'd1);
    check("t8_busy", 32'(busy), 32'd0);
    check("t8_done", 32'(done), 32'd0);
    check("t8_error", 32'(error), 32'd0);
    check("t8_code", 32'(error_code), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

`ifdef LOADER_VERIFY_EN
    // Read-back pass against a memory corrupting address 5, then a clean one.
    sum = 32'd0;
    for (int i = 0; i < 8; i++) begin
      img[i] = 32'h10000001 * 32'(i + 1);
      sum    = sum + img[i];
    end
    clear_mon();
    corrupt = 1'b1;
    pulse_start();
    load_image(8, sum, 1'b0);
    wait_end("v1_end", 300);
    check("v1_error", 32'(error), 32'd1);
    check("v1_code", 32'(error_code), 32'd3);
    check("v1_cpu_reset", 32'(cpu_reset_req), 32'd1);
    clear_mon();
    corrupt = 1'b0;
    pulse_start();
    load_image(8, sum, 1'b0);
    wait_end("v2_end", 300);
    check("v2_done", 32'(done), 32'd1);
    check("v2_reads", 32'(rd_total), 32'd8);
`else
    check("no_read_cycles", 32'(rd_ever), 32'd0);
`endif

    check("strobe_consistency", 32'(bad_strobe), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
